// File: rtl/ama_riscv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// ama_riscv_wb_arbiter
//
// Drives the write port of the register file. It merges the execute-stage ALU
// result stream with the data-memory load-return stream. Load returns that lose
// arbitration are parked in a small FIFO. The decode stage can see:
//   - forwarding from the write that is currently on the port, and
//   - a pending flag for any destination that still sits in the FIFO.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   alu_valid/rd/data     ALU result offer
//   alu_ready             ALU result accepted when alu_valid & alu_ready
//   ld_valid/rd/data      load return (already extracted and extended)
//   ld_ready              load return accepted when ld_valid & ld_ready
//   rf_we/addr_d/data_d   registered register-file write port
//   addr_a, addr_b        decode-stage source registers
//   fwd_{a,b}_hit/data    source matches the write on the port this cycle
//   pend_{a,b}            source matches a live buffered load (decode stalls)
// -----------------------------------------------------------------------------
module ama_riscv_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  // ALU result
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  // load return
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  // register-file write port
  output logic        rf_we,
  output logic [4:0]  rf_addr_d,
  output logic [31:0] rf_data_d,
  // decode-stage lookups
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  output logic        fwd_a_hit,
  output logic        fwd_b_hit,
  output logic [31:0] fwd_a_data,
  output logic [31:0] fwd_b_data,
  output logic        pend_a,
  output logic        pend_b
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_ALU,
    WIN_BUF,
    WIN_BYPASS
  } win_e;

  // ---------------------------------------------------------------------------
  // Load buffer state
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [DEPTH-1:0] r_vld;
  logic [4:0]       r_ent_rd   [DEPTH];
  logic [31:0]      r_ent_data [DEPTH];

  // Output stage
  logic        r_rf_we;
  logic [4:0]  r_rf_addr;
  logic [31:0] r_rf_data;

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_head_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_head_valid;

  assign w_wr_idx     = r_wr_ptr[AW-1:0];
  assign w_head_idx   = r_rd_ptr[AW-1:0];
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head_valid = r_vld[w_head_idx];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_alu_acc;
  logic w_alu_win;
  logic w_pop;
  logic w_ld_ready;
  logic w_ld_acc;
  logic w_ld_live;
  logic w_ld_killed;
  logic w_bypass;
  logic w_push;

  // A full buffer always pops its head. That is how loads make forward
  // progress against a continuous ALU stream. As a result, ld_ready can only
  // drop if a full buffer fails to pop.
  assign w_alu_acc   = alu_valid & ~w_full;
  assign w_alu_win   = w_alu_acc & (alu_rd != 5'd0);
  assign w_pop       = w_full | (~w_alu_win & ~w_empty);
  assign w_ld_ready  = ~w_full | w_pop;
  assign w_ld_acc    = ld_valid & w_ld_ready;
  assign w_ld_live   = w_ld_acc & (ld_rd != 5'd0);
  assign w_bypass    = w_ld_live & w_empty & ~w_alu_win;
  // The ALU instruction is younger than any outstanding load. Its write
  // supersedes a same-cycle load to the same destination.
  assign w_ld_killed = w_alu_win & (ld_rd == alu_rd);
  assign w_push      = w_ld_live & ~w_bypass & ~w_ld_killed;

  assign alu_ready = ~w_full;
  assign ld_ready  = w_ld_ready;

  win_e        w_win;
  logic        w_we_nxt;
  logic [4:0]  w_addr_nxt;
  logic [31:0] w_data_nxt;

  always_comb begin
    w_win = WIN_NONE;
    if (w_alu_win) begin
      w_win = WIN_ALU;
    end else if (w_pop) begin
      w_win = WIN_BUF;
    end else if (w_bypass) begin
      w_win = WIN_BYPASS;
    end
  end

  always_comb begin
    w_we_nxt   = 1'b0;
    w_addr_nxt = alu_rd;
    w_data_nxt = alu_data;
    case (w_win)
      WIN_ALU: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = alu_rd;
        w_data_nxt = alu_data;
      end
      WIN_BUF: begin
        // A killed entry still drains through the port slot but writes nothing.
        w_we_nxt   = w_head_valid;
        w_addr_nxt = r_ent_rd[w_head_idx];
        w_data_nxt = r_ent_data[w_head_idx];
      end
      WIN_BYPASS: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = ld_rd;
        w_data_nxt = ld_data;
      end
      default: begin
        w_we_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Buffer control: kill, pop, push
  // ---------------------------------------------------------------------------
  // Kill and pop never coincide: pop happens only when the ALU does not win.
  // On a full buffer, a push targets the slot being popped. The push is
  // written last, so its valid bit takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vld    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_alu_win && (r_ent_rd[AW'(i)] == alu_rd)) begin
          r_vld[AW'(i)] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_vld[w_head_idx] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_vld[w_wr_idx] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
    end
  end

  // Entry payload needs no reset. It is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_rd[w_wr_idx]   <= ld_rd;
      r_ent_data[w_wr_idx] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: address/data hold their value when nothing is written
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= w_we_nxt;
      if (w_we_nxt) begin
        r_rf_addr <= w_addr_nxt;
        r_rf_data <= w_data_nxt;
      end
    end
  end

  assign rf_we     = r_rf_we;
  assign rf_addr_d = r_rf_addr;
  assign rf_data_d = r_rf_data;

  // ---------------------------------------------------------------------------
  // Decode-stage lookups
  // ---------------------------------------------------------------------------
  assign fwd_a_hit  = r_rf_we & (r_rf_addr == addr_a) & (addr_a != 5'd0);
  assign fwd_b_hit  = r_rf_we & (r_rf_addr == addr_b) & (addr_b != 5'd0);
  assign fwd_a_data = fwd_a_hit ? r_rf_data : '0;
  assign fwd_b_data = fwd_b_hit ? r_rf_data : '0;

  logic w_pend_a_any;
  logic w_pend_b_any;

  // Valid bits are cleared on pop and reset, so a set bit implies an occupied slot.
  always_comb begin
    w_pend_a_any = 1'b0;
    w_pend_b_any = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[AW'(i)] && (r_ent_rd[AW'(i)] == addr_a)) w_pend_a_any = 1'b1;
      if (r_vld[AW'(i)] && (r_ent_rd[AW'(i)] == addr_b)) w_pend_b_any = 1'b1;
    end
  end

  assign pend_a = w_pend_a_any & (addr_a != 5'd0);
  assign pend_b = w_pend_b_any & (addr_b != 5'd0);

endmodule

// File: tb/tb_ama_riscv_wb_arbiter.sv
module tb_ama_riscv_wb_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data_d;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [31:0] fwd_a_data;
  logic [31:0] fwd_b_data;
  logic        pend_a;
  logic        pend_b;

  ama_riscv_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .rf_we     (rf_we),
    .rf_addr_d (rf_addr_d),
    .rf_data_d (rf_data_d),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .fwd_a_hit (fwd_a_hit),
    .fwd_b_hit (fwd_b_hit),
    .fwd_a_data(fwd_a_data),
    .fwd_b_data(fwd_b_data),
    .pend_a    (pend_a),
    .pend_b    (pend_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: an ordered list of buffered loads plus the write port.
  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
  } ent_t;

  ent_t      mq[$];
  bit        m_rf_we;
  bit [4:0]  m_rf_addr;
  bit [31:0] m_rf_data;

  // Predicted combinational outputs for the cycle being driven
  bit        p_alu_ready, p_ld_ready, p_pend_a, p_pend_b, p_fwd_a_hit, p_fwd_b_hit;
  bit [31:0] p_fwd_a_data, p_fwd_b_data;
  // DUT combinational outputs sampled in the same cycle
  logic        s_alu_ready, s_ld_ready, s_pend_a, s_pend_b, s_fwd_a_hit, s_fwd_b_hit;
  logic [31:0] s_fwd_a_data, s_fwd_b_data;

  bit [4:0] wlog[$];

  function automatic bit m_pend(input bit [4:0] a);
    foreach (mq[i]) if (mq[i].v && mq[i].rd == a && a != 5'd0) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle starting just after a negedge. Return at the next negedge.
  task automatic step(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                      input bit lv, input bit [4:0] lrd, input bit [31:0] ldd);
    bit full, empty, alu_win, pop, ld_acc, live, byp, we;
    bit [4:0] wa;
    bit [31:0] wd;
    ent_t h;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    full    = (mq.size() == DEPTH);
    empty   = (mq.size() == 0);
    alu_win = av && !full && ard != 5'd0;
    pop     = full || (!alu_win && !empty);
    p_alu_ready  = !full;
    p_ld_ready   = !full || pop;
    p_pend_a     = m_pend(addr_a);
    p_pend_b     = m_pend(addr_b);
    p_fwd_a_hit  = m_rf_we && m_rf_addr == addr_a && addr_a != 5'd0;
    p_fwd_b_hit  = m_rf_we && m_rf_addr == addr_b && addr_b != 5'd0;
    p_fwd_a_data = p_fwd_a_hit ? m_rf_data : 32'd0;
    p_fwd_b_data = p_fwd_b_hit ? m_rf_data : 32'd0;
    #1;
    s_alu_ready = alu_ready; s_ld_ready = ld_ready;
    s_pend_a = pend_a; s_pend_b = pend_b;
    s_fwd_a_hit = fwd_a_hit; s_fwd_b_hit = fwd_b_hit;
    s_fwd_a_data = fwd_a_data; s_fwd_b_data = fwd_b_data;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_rf_we = 1'b0; m_rf_addr = '0; m_rf_data = '0;
    end else begin
      ld_acc = lv && p_ld_ready;
      live   = ld_acc && lrd != 5'd0;
      byp    = live && empty && !alu_win;
      we = 1'b0; wa = '0; wd = '0;
      if (alu_win) begin
        we = 1'b1; wa = ard; wd = ad;
        foreach (mq[i]) if (mq[i].rd == ard) mq[i].v = 1'b0;
      end else if (pop) begin
        h = mq.pop_front();
        if (h.v) begin we = 1'b1; wa = h.rd; wd = h.d; end
      end else if (byp) begin
        we = 1'b1; wa = lrd; wd = ldd;
      end
      if (live && !byp && !(alu_win && lrd == ard))
        mq.push_back('{v: 1'b1, rd: lrd, d: ldd});
      m_rf_we = we;
      if (we) begin m_rf_addr = wa; m_rf_data = wd; end
    end
    @(negedge clk);
    if (rf_we === 1'b1) wlog.push_back(rf_addr_d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    addr_a = 5'd0; addr_b = 5'd0;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0; #1;
    checks++;
    if (rf_we !== 1'b0 || rf_addr_d !== 5'd0 || rf_data_d !== 32'd0) begin
      failures++;
      $display("FAIL reset_port: got we=%b addr=%0d data=%h, expected 0/0/0", rf_we, rf_addr_d, rf_data_d);
    end
    checks++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got alu_ready=%b ld_ready=%b, expected 1/1", alu_ready, ld_ready);
    end
    checks++;
    if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || pend_a !== 1'b0 || pend_b !== 1'b0 ||
        fwd_a_data !== 32'd0 || fwd_b_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_lookup: got fa=%b fb=%b pa=%b pb=%b, expected all 0", fwd_a_hit, fwd_b_hit, pend_a, pend_b);
    end
  endtask

  task automatic test_alu_only();
    addr_a = 5'd0; addr_b = 5'd0;
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checks++;
    if (rf_we !== 1'b1 || rf_addr_d !== 5'd5 || rf_data_d !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL alu_write: got we=%b addr=%0d data=%h, expected 1/5/deadbeef", rf_we, rf_addr_d, rf_data_d);
    end
    addr_a = 5'd5; addr_b = 5'd6; #1;
    checks++;
    if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL alu_fwd_a: got hit=%b data=%h, expected 1/deadbeef", fwd_a_hit, fwd_a_data);
    end
    checks++;
    if (fwd_b_hit !== 1'b0 || fwd_b_data !== 32'd0) begin
      failures++;
      $display("FAIL alu_fwd_b_miss: got hit=%b data=%h, expected 0/0", fwd_b_hit, fwd_b_data);
    end
    idle();
    checks++;
    if (rf_we !== 1'b0 || rf_addr_d !== 5'd5 || rf_data_d !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL alu_hold: got we=%b addr=%0d data=%h, expected 0/5/deadbeef", rf_we, rf_addr_d, rf_data_d);
    end
  endtask

  task automatic test_conflict();
    addr_a = 5'd0; addr_b = 5'd0;
    step(1'b0, 1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd7, 32'h0000_0777);
    checks++;
    if (rf_we !== 1'b1 || rf_addr_d !== 5'd3 || rf_data_d !== 32'h333) begin
      failures++;
      $display("FAIL conflict_alu: got we=%b addr=%0d data=%h, expected 1/3/333", rf_we, rf_addr_d, rf_data_d);
    end
    addr_b = 5'd7; #1;
    checks++;
    if (pend_b !== 1'b1) begin
      failures++;
      $display("FAIL conflict_pend: got pend_b=%b, expected 1", pend_b);
    end
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_addr_d !== 5'd7 || rf_data_d !== 32'h777) begin
      failures++;
      $display("FAIL conflict_load: got we=%b addr=%0d data=%h, expected 1/7/777", rf_we, rf_addr_d, rf_data_d);
    end
    checks++;
    if (pend_b !== 1'b0) begin
      failures++;
      $display("FAIL conflict_pend_clear: got pend_b=%b, expected 0", pend_b);
    end
  endtask

  task automatic test_fill_starve();
    bit [4:0] exp_log[5];
    exp_log = '{5'd1, 5'd1, 5'd8, 5'd1, 5'd9};
    addr_a = 5'd0; addr_b = 5'd0;
    wlog.delete();
    step(1'b0, 1'b1, 5'd1, 32'h1000, 1'b1, 5'd8, 32'h8888);
    step(1'b0, 1'b1, 5'd1, 32'h1001, 1'b1, 5'd9, 32'h9999);
    checks++;
    if (alu_ready !== 1'b0 || ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_ready: got alu_ready=%b ld_ready=%b, expected 0/1", alu_ready, ld_ready);
    end
    step(1'b0, 1'b1, 5'd1, 32'h1002, 1'b0, 5'd0, 32'd0);
    checks++;
    if (rf_we !== 1'b1 || rf_addr_d !== 5'd8 || rf_data_d !== 32'h8888) begin
      failures++;
      $display("FAIL fill_first_load: got we=%b addr=%0d data=%h, expected 1/8/8888", rf_we, rf_addr_d, rf_data_d);
    end
    step(1'b0, 1'b1, 5'd1, 32'h1002, 1'b0, 5'd0, 32'd0);
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_addr_d !== 5'd9 || rf_data_d !== 32'h9999) begin
      failures++;
      $display("FAIL fill_second_load: got we=%b addr=%0d data=%h, expected 1/9/9999", rf_we, rf_addr_d, rf_data_d);
    end
    checks++;
    if (wlog.size() != 5 || wlog[0] != exp_log[0] || wlog[1] != exp_log[1] || wlog[2] != exp_log[2] ||
        wlog[3] != exp_log[3] || wlog[4] != exp_log[4]) begin
      failures++;
      $display("FAIL fill_order: got %0d writes, expected sequence 1,1,8,1,9", wlog.size());
    end
  endtask

  task automatic test_waw_kill();
    addr_a = 5'd0; addr_b = 5'd0;
    wlog.delete();
    step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    addr_a = 5'd4; #1;
    checks++;
    if (pend_a !== 1'b1) begin
      failures++;
      $display("FAIL waw_pend: got pend_a=%b, expected 1", pend_a);
    end
    step(1'b0, 1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 32'd0);
    checks++;
    if (rf_we !== 1'b1 || rf_addr_d !== 5'd4 || rf_data_d !== 32'h11 || pend_a !== 1'b0) begin
      failures++;
      $display("FAIL waw_alu: got we=%b addr=%0d data=%h pend_a=%b, expected 1/4/11/0", rf_we, rf_addr_d, rf_data_d, pend_a);
    end
    idle();
    checks++;
    if (rf_we !== 1'b0 || rf_addr_d !== 5'd4 || rf_data_d !== 32'h11) begin
      failures++;
      $display("FAIL waw_dead_pop: got we=%b addr=%0d data=%h, expected 0/4/11", rf_we, rf_addr_d, rf_data_d);
    end
    // same-cycle load to the ALU destination is dropped
    addr_b = 5'd6;
    step(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h60);
    checks++;
    if (pend_b !== 1'b0 || rf_data_d !== 32'h66) begin
      failures++;
      $display("FAIL waw_same_cycle: got pend_b=%b data=%h, expected 0/66", pend_b, rf_data_d);
    end
    idle();
    checks++;
    if (wlog.size() != 3 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL waw_write_count: got %0d writes we=%b, expected 3 writes we=0", wlog.size(), rf_we);
    end
  endtask

  task automatic test_x0();
    addr_a = 5'd0; addr_b = 5'd0;
    wlog.delete();
    step(1'b0, 1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCCCC);
    step(1'b0, 1'b1, 5'd0, 32'hDDDD, 1'b0, 5'd0, 32'd0);
    idle();
    checks++;
    if (wlog.size() != 0) begin
      failures++;
      $display("FAIL x0_no_write: got %0d writes, expected 0", wlog.size());
    end
    // ALU to x0 takes no slot: a same-cycle load bypasses to the port
    step(1'b0, 1'b1, 5'd0, 32'hEEEE, 1'b1, 5'd12, 32'h0C0C);
    checks++;
    if (rf_we !== 1'b1 || rf_addr_d !== 5'd12 || rf_data_d !== 32'h0C0C || pend_a !== 1'b0) begin
      failures++;
      $display("FAIL x0_bypass: got we=%b addr=%0d data=%h, expected 1/12/0c0c", rf_we, rf_addr_d, rf_data_d);
    end
    checks++;
    if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || pend_b !== 1'b0) begin
      failures++;
      $display("FAIL x0_lookup: got fa=%b fb=%b pb=%b, expected 0/0/0", fwd_a_hit, fwd_b_hit, pend_b);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    addr_a = 5'd0; addr_b = 5'd0;
    step(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hA0);
    step(1'b0, 1'b1, 5'd2, 32'h3, 1'b1, 5'd11, 32'hB0);
    addr_a = 5'd10; addr_b = 5'd11; #1;
    checks++;
    if (pend_a !== 1'b1 || pend_b !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pend_before: got pa=%b pb=%b, expected 1/1", pend_a, pend_b);
    end
    step(1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd13, 32'hD0);
    checks++;
    if (rf_we !== 1'b0 || ld_ready !== 1'b1 || alu_ready !== 1'b1 || pend_a !== 1'b0 || pend_b !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state: got we=%b ldr=%b alur=%b pa=%b pb=%b, expected 0/1/1/0/0",
               rf_we, ld_ready, alu_ready, pend_a, pend_b);
    end
    wlog.delete();
    idle(); idle(); idle();
    checks++;
    if (wlog.size() != 0) begin
      failures++;
      $display("FAIL rstmid_stale: got %0d writes after reset, expected 0", wlog.size());
    end
  endtask

  task automatic test_random();
    bit r, av, lv;
    bit [4:0] ard, lrd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r   = ($urandom_range(0, 149) == 0);
      av  = ($urandom_range(0, 99) < 60);
      lv  = ($urandom_range(0, 99) < 55);
      ard = 5'($urandom_range(0, 7));
      lrd = 5'($urandom_range(0, 7));
      addr_a = 5'($urandom_range(0, 7));
      addr_b = 5'($urandom_range(0, 7));
      step(r, av, ard, $urandom, lv, lrd, $urandom);
      checks++;
      if (s_alu_ready !== p_alu_ready || s_ld_ready !== p_ld_ready) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d: got alu=%b ld=%b, expected alu=%b ld=%b",
                 cyc, s_alu_ready, s_ld_ready, p_alu_ready, p_ld_ready);
      end
      checks++;
      if (s_pend_a !== p_pend_a || s_pend_b !== p_pend_b) begin
        failures++;
        $display("FAIL rnd_pend cyc=%0d: got a=%b b=%b, expected a=%b b=%b",
                 cyc, s_pend_a, s_pend_b, p_pend_a, p_pend_b);
      end
      checks++;
      if (s_fwd_a_hit !== p_fwd_a_hit || s_fwd_a_data !== p_fwd_a_data ||
          s_fwd_b_hit !== p_fwd_b_hit || s_fwd_b_data !== p_fwd_b_data) begin
        failures++;
        $display("FAIL rnd_fwd cyc=%0d: got a=%b/%h b=%b/%h, expected a=%b/%h b=%b/%h", cyc,
                 s_fwd_a_hit, s_fwd_a_data, s_fwd_b_hit, s_fwd_b_data,
                 p_fwd_a_hit, p_fwd_a_data, p_fwd_b_hit, p_fwd_b_data);
      end
      checks++;
      if (rf_we !== m_rf_we || rf_addr_d !== m_rf_addr || rf_data_d !== m_rf_data) begin
        failures++;
        $display("FAIL rnd_port cyc=%0d: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                 cyc, rf_we, rf_addr_d, rf_data_d, m_rf_we, m_rf_addr, m_rf_data);
      end
    end
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; addr_a = '0; addr_b = '0;
    @(negedge clk);
    test_reset();
    test_alu_only();
    test_conflict();
    test_fill_starve();
    test_waw_kill();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
